pid_sequencer: RTL and testbench
================================

PID_SEQUENCER -- requirements
Module: pid_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port clr, input, 1, synchronous soft clear.
REQ-004 SHALL have port sample_valid, input, 1, one-cycle strobe from the ADC: target/y valid.
REQ-005 SHALL have port target, input, 10, unsigned setpoint.
REQ-006 SHALL have port y, input, 10, unsigned measured value.
REQ-007 SHALL have ports kp, ki, kd, input, 8 each, unsigned gains, sampled on accept.
REQ-008 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-009 SHALL have port duty, output, 10, unsigned PWM compare value.
REQ-010 SHALL have port duty_valid, output, 1, one-cycle pulse when duty updates.
REQ-011 SHALL have port overrun, output, 1, sticky flag for a sample dropped while busy.

Function
REQ-012 SHALL run FSM IDLE->ERR->MP->MI->MD->UPD->IDLE, one cycle per state.
REQ-013 SHALL accept a sample only when in IDLE and sample_valid=1, latching target, y, kp, ki, kd.
REQ-014 SHALL, in ERR, compute e0 = target - y as 11-bit signed, with no truncation.
REQ-015 SHALL form d1 = e0 - e1 and d2 = e0 - 2*e1 + e2 as 13-bit signed.
REQ-016 SHALL accumulate du (24-bit signed) by time-sharing one multiplier: MP adds kp*d1, MI adds ki*e0, MD adds kd*d2; du is cleared on accept.
REQ-017 SHALL, in UPD, set u_acc = u_acc + du (24-bit signed, Q.6), e2 = e1 and e1 = e0; error history updates only in UPD, never per clock.
REQ-018 SHALL register duty = low 10 bits of (u_acc >>> 6) and pulse duty_valid in the cycle after UPD, i.e. 6 cycles after the accepting edge.
REQ-019 SHALL, because IDLE is re-entered in the duty_valid cycle, accept a sample_valid in that same cycle (throughput one sample per 6 cycles).
REQ-020 SHALL set overrun when sample_valid=1 while not in IDLE; the sample is dropped and the in-flight computation is unaffected.
REQ-021 SHALL give clr highest priority: zero e1, e2, du, u_acc, duty and overrun, deassert duty_valid, and go to IDLE from any state.
REQ-022 SHALL, on clr and sample_valid in the same cycle, drop the sample and leave overrun clear.
REQ-023 SHALL hold duty between updates.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force state=IDLE and busy=0, duty=0, duty_valid=0, overrun=0, e1=e2=0, du=0, u_acc=0.
REQ-025 SHALL, on reset mid-computation, abort the computation with no duty_valid; the first accept after release computes from zero history.

Configuration
REQ-026 SHALL, with macro PID_CLAMP_EN defined, clamp u_acc after each UPD to [0, 65472] (anti-windup), so duty saturates at 0..1023.
REQ-027 SHALL, without PID_CLAMP_EN, let u_acc wrap at 24 bits and let duty take the low 10 bits unsaturated.

Structure
REQ-028 SHALL place widths (ADC_W=10, E_W=11, D_W=13, ACC_W=24), FRAC=6, UMAX=65472 and the FSM state enum in shared package pid_pkg.
REQ-029 SHALL implement the shared multiply-accumulate (8-bit unsigned x 13-bit signed into 24-bit du) as sub-module pid_mac.

Verification
REQ-030 SHALL cover: reset, then kp=16, ki=8, kd=0, target=512, y=500 -> duty_valid 6 cycles after accept, duty=4 (u_acc=288).
REQ-031 SHALL cover: the same sample repeated -> duty=6 (u_acc=384; e1=12 so the kp term is 0).
REQ-032 SHALL cover: from reset, kp=ki=kd=255, target=1023, y=0 -> with PID_CLAMP_EN duty=1023; without it duty=964 (u_acc=782595).
REQ-033 SHALL cover: from reset, kp=16, ki=kd=0, target=0, y=100 -> with PID_CLAMP_EN duty=0; without it duty=999.
REQ-034 SHALL cover: sample_valid 2 cycles after accept -> overrun=1, the first result is unchanged, and no second duty_valid.
REQ-035 SHALL cover: clr asserted in state MI -> no duty_valid, duty=0, busy=0 next cycle; clr together with sample_valid -> no accept and overrun=0.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared widths, FSM encoding and sample payload for the PID sequencer.
package pid_pkg;

    localparam int unsigned ADC_W  = 10;
    localparam int unsigned E_W    = 11;
    localparam int unsigned D_W    = 13;
    localparam int unsigned ACC_W  = 24;
    localparam int unsigned GAIN_W = 8;
    localparam int unsigned FRAC   = 6;
    localparam int unsigned UMAX   = 65472;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ERR  = 3'd1,
        ST_MP   = 3'd2,
        ST_MI   = 3'd3,
        ST_MD   = 3'd4,
        ST_UPD  = 3'd5
    } state_t;

    typedef struct packed {
        logic [ADC_W-1:0]  target;
        logic [ADC_W-1:0]  y;
        logic [GAIN_W-1:0] kp;
        logic [GAIN_W-1:0] ki;
        logic [GAIN_W-1:0] kd;
    } sample_t;

    // Anti-windup saturation of the Q.6 accumulator to [0, UMAX].
    function automatic logic signed [ACC_W-1:0] clamp_u(input logic signed [ACC_W-1:0] u);
        if (u[ACC_W-1]) begin
            return '0;
        end else if (u > signed'(ACC_W'(UMAX))) begin
            return signed'(ACC_W'(UMAX));
        end else begin
            return u;
        end
    endfunction

endpackage

// File: rtl/pid_mac.sv
// Time-shared multiply-accumulate: du += gain (unsigned) * opnd (signed).
module pid_mac
    import pid_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic [GAIN_W-1:0]       gain,
    input  logic signed [D_W-1:0]   opnd,
    output logic signed [ACC_W-1:0] du
);

    logic signed [ACC_W-1:0] prod_c;

    // Full product fits in 22 bits, so 24-bit arithmetic is exact.
    always_comb begin
        prod_c = ACC_W'(signed'({1'b0, gain})) * ACC_W'(opnd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            du <= '0;
        end else if (clr) begin
            du <= '0;
        end else if (en) begin
            du <= du + prod_c;
        end
    end

endmodule

// File: rtl/pid_sequencer.sv
// Incremental PID controller producing a PWM duty value, one sample per 6 cycles.
// Define PID_CLAMP_EN to saturate the accumulator (anti-windup) instead of wrapping.
module pid_sequencer
    import pid_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              sample_valid,
    input  logic [ADC_W-1:0]  target,
    input  logic [ADC_W-1:0]  y,
    input  logic [GAIN_W-1:0] kp,
    input  logic [GAIN_W-1:0] ki,
    input  logic [GAIN_W-1:0] kd,
    output logic              busy,
    output logic [ADC_W-1:0]  duty,
    output logic              duty_valid,
    output logic              overrun
);

    state_t                  state;
    state_t                  state_nxt;
    sample_t                 smp;
    logic signed [E_W-1:0]   e0;
    logic signed [E_W-1:0]   e1;
    logic signed [E_W-1:0]   e2;
    logic signed [ACC_W-1:0] u_acc;
    logic signed [ACC_W-1:0] du;
    logic signed [ACC_W-1:0] u_sum_c;
    logic signed [ACC_W-1:0] u_nxt_c;
    logic signed [D_W-1:0]   d1_c;
    logic signed [D_W-1:0]   d2_c;
    logic signed [D_W-1:0]   mac_opnd_c;
    logic [GAIN_W-1:0]       mac_gain_c;
    logic                    mac_en_c;
    logic                    accept_c;

    always_comb begin
        d1_c = D_W'(e0) - D_W'(e1);
        d2_c = D_W'(e0) - (D_W'(e1) <<< 1) + D_W'(e2);
    end

    always_comb begin
        u_sum_c = u_acc + du;
`ifdef PID_CLAMP_EN
        u_nxt_c = clamp_u(u_sum_c);
`else
        u_nxt_c = u_sum_c;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus multiplier operand selection; clr wins over everything.
    always_comb begin
        state_nxt  = state;
        accept_c   = 1'b0;
        mac_en_c   = 1'b0;
        mac_gain_c = '0;
        mac_opnd_c = '0;
        if (clr) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sample_valid) begin
                        accept_c  = 1'b1;
                        state_nxt = ST_ERR;
                    end
                end
                ST_ERR: state_nxt = ST_MP;
                ST_MP: begin
                    mac_en_c   = 1'b1;
                    mac_gain_c = smp.kp;
                    mac_opnd_c = d1_c;
                    state_nxt  = ST_MI;
                end
                ST_MI: begin
                    mac_en_c   = 1'b1;
                    mac_gain_c = smp.ki;
                    mac_opnd_c = D_W'(e0);
                    state_nxt  = ST_MD;
                end
                ST_MD: begin
                    mac_en_c   = 1'b1;
                    mac_gain_c = smp.kd;
                    mac_opnd_c = d2_c;
                    state_nxt  = ST_UPD;
                end
                ST_UPD:  state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    pid_mac u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr | accept_c),
        .en    (mac_en_c),
        .gain  (mac_gain_c),
        .opnd  (mac_opnd_c),
        .du    (du)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_nxt != ST_IDLE);
        end
    end

    // Datapath: sample latch, error history, accumulator and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp        <= '0;
            e0         <= '0;
            e1         <= '0;
            e2         <= '0;
            u_acc      <= '0;
            duty       <= '0;
            duty_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (clr) begin
            e1         <= '0;
            e2         <= '0;
            u_acc      <= '0;
            duty       <= '0;
            duty_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (accept_c) begin
                smp <= '{target: target, y: y, kp: kp, ki: ki, kd: kd};
            end
            if (sample_valid && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            if (state == ST_ERR) begin
                e0 <= signed'({1'b0, smp.target}) - signed'({1'b0, smp.y});
            end
            if (state == ST_UPD) begin
                u_acc      <= u_nxt_c;
                e2         <= e1;
                e1         <= e0;
                duty       <= u_nxt_c[FRAC +: ADC_W];
                duty_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pid_sequencer.sv
// Self-checking bench for pid_sequencer: directed cases plus randomized samples
// compared against an arithmetic model of the incremental PID law.
module tb_pid_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       sample_valid = 1'b0;
    logic [9:0] target = '0;
    logic [9:0] y = '0;
    logic [7:0] kp = '0;
    logic [7:0] ki = '0;
    logic [7:0] kd = '0;
    logic       busy;
    logic [9:0] duty;
    logic       duty_valid;
    logic       overrun;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int m_e1, m_e2, m_u, m_exp;

    pid_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .sample_valid (sample_valid),
        .target       (target),
        .y            (y),
        .kp           (kp),
        .ki           (ki),
        .kd           (kd),
        .busy         (busy),
        .duty         (duty),
        .duty_valid   (duty_valid),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_e1 = 0;
        m_e2 = 0;
        m_u  = 0;
    endtask

    // Incremental PID: du = kp*(e0-e1) + ki*e0 + kd*(e0-2e1+e2), u += du.
    task automatic model_step(input int t, input int yy, input int p, input int i, input int d);
        int e0;
        e0 = t - yy;
        m_u = m_u + p * (e0 - m_e1) + i * e0 + d * (e0 - 2 * m_e1 + m_e2);
`ifdef PID_CLAMP_EN
        if (m_u < 0) m_u = 0;
        else if (m_u > 65472) m_u = 65472;
`else
        m_u = m_u & 32'h00FF_FFFF;
        if (m_u >= 8388608) m_u = m_u - 16777216;
`endif
        m_e2  = m_e1;
        m_e1  = e0;
        m_exp = (m_u >>> 6) & 1023;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr = 1'b0;
        sample_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        model_clear();
    endtask

    // Drive one sample through the accepting edge; the model advances with it.
    task automatic start_sample(input int t, input int yy, input int p, input int i, input int d);
        target = 10'(t);
        y = 10'(yy);
        kp = 8'(p);
        ki = 8'(i);
        kd = 8'(d);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        acc_cyc = cyc;
        chk("busy_after_accept", busy, 1);
        chk("dv_low_after_accept", duty_valid, 0);
        model_step(t, yy, p, i, d);
    endtask

    // Wait for the duty_valid pulse; accept cycle is cycle 0, pulse is in cycle 6.
    task automatic finish_sample(input string tag);
        int n;
        n = 0;
        while (!duty_valid && n < 12) begin
            step();
            n++;
        end
        chk({tag, "_seen"}, duty_valid, 1);
        chk({tag, "_latency"}, cyc - acc_cyc, 5);
        chk({tag, "_duty"}, duty, m_exp);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic expect_no_dv(input string tag, input int cycles, input int held);
        for (int k = 0; k < cycles; k++) begin
            step();
            chk({tag, "_no_dv"}, duty_valid, 0);
            chk({tag, "_hold"}, duty, held);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hold;
        int gap;
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_duty", duty, 0);
        chk("rst_dv", duty_valid, 0);
        chk("rst_overrun", overrun, 0);

        start_sample(512, 500, 16, 8, 0);
        finish_sample("dir1");
        chk("dir1_const", duty, 4);
        // Back-to-back: next sample accepted in the duty_valid cycle.
        start_sample(512, 500, 16, 8, 0);
        finish_sample("dir2");
        chk("dir2_const", duty, 6);
        expect_no_dv("dir2", 2, 6);

        do_reset();
        start_sample(1023, 0, 255, 255, 255);
        finish_sample("max");
`ifdef PID_CLAMP_EN
        chk("max_const", duty, 1023);
`else
        chk("max_const", duty, 964);
`endif

        do_reset();
        start_sample(0, 100, 16, 0, 0);
        finish_sample("neg");
`ifdef PID_CLAMP_EN
        chk("neg_const", duty, 0);
`else
        chk("neg_const", duty, 999);
`endif

        // Sample arriving mid-computation is dropped and flagged.
        do_reset();
        start_sample(512, 500, 16, 8, 0);
        step();
        target = 10'd0;
        y = 10'd900;
        kp = 8'd200;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        chk("ovr_flag", overrun, 1);
        finish_sample("ovr");
        chk("ovr_const", duty, 4);
        expect_no_dv("ovr", 10, 4);
        chk("ovr_sticky", overrun, 1);

        // clr during MI aborts and clears duty/overrun.
        start_sample(700, 100, 50, 20, 10);
        step();
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        model_clear();
        chk("clr_busy", busy, 0);
        chk("clr_duty", duty, 0);
        chk("clr_dv", duty_valid, 0);
        chk("clr_overrun", overrun, 0);
        expect_no_dv("clr", 8, 0);

        // clr with sample_valid: no accept, no overrun.
        start_sample(300, 200, 10, 10, 10);
        step();
        clr = 1'b1;
        sample_valid = 1'b1;
        step();
        clr = 1'b0;
        sample_valid = 1'b0;
        model_clear();
        chk("clrsv_busy_overrun", overrun, 0);
        chk("clrsv_busy_busy", busy, 0);
        clr = 1'b1;
        sample_valid = 1'b1;
        step();
        clr = 1'b0;
        sample_valid = 1'b0;
        chk("clrsv_idle_busy", busy, 0);
        chk("clrsv_idle_overrun", overrun, 0);
        expect_no_dv("clrsv", 8, 0);

        // Reset mid-computation: no result, next sample starts from zero history.
        start_sample(512, 500, 16, 8, 0);
        finish_sample("pre_rst");
        start_sample(512, 500, 16, 8, 0);
        step();
        rst_n = 1'b0;
        #2;
        chk("arst_busy", busy, 0);
        chk("arst_duty", duty, 0);
        chk("arst_dv", duty_valid, 0);
        step();
        rst_n = 1'b1;
        model_clear();
        expect_no_dv("arst", 8, 0);
        start_sample(512, 500, 16, 8, 0);
        finish_sample("post_rst");
        chk("post_rst_const", duty, 4);

        // Randomized samples with random idle gaps (gap 0 = back-to-back).
        for (int n = 0; n < 40; n++) begin
            start_sample(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                         int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                         int'($urandom_range(0, 255)));
            finish_sample("rnd");
            hold = m_exp;
            gap = int'($urandom_range(0, 3));
            if (gap > 0) expect_no_dv("rnd_gap", gap, hold);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
